fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS32 pipeline, directly upstream of decode. Owns the PC, drives the byte address into the combinational instruction ROM and registers the returned word into the IF/ID pipeline register. Handles load-use stalls, branch and jump redirects with wrong-path squash, and keeps fetch and stall performance counters.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/fetch_perf_ctr.sv | 34 +++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS32 pipeline.
//   PC_W        default PC / instruction-ROM byte-address width
//   NOP_INSTR   word used to fill a squashed pipeline slot
//   OP_J/OP_BEQ primary opcodes of the control-flow instructions
//   npc_sel_e   the action chosen by the fetch stage at each edge
package mips_pkg;

  localparam int PC_W = 10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    SEQ,
    HOLD,
    REDIRECT_BR,
    REDIRECT_J
  } npc_sel_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: pair of enable-driven performance counters.
//   clk, reset        clock, asynchronous active-high reset
//   fetch_en          count one valid instruction written into IF/ID
//   stall_en          count one cycle spent in hold
//   fetch_count       running fetch total, wraps at 2^CNT_W
//   stall_count       running stall total, wraps at 2^CNT_W
module fetch_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic             stall_en,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (fetch_en) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_en) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS32 pipeline.
//   clk, reset        clock, asynchronous active-high reset
//   imem_addr         byte address to the combinational instruction ROM (= pc)
//   imem_data         instruction word returned by the ROM
//   stall             load-use hold from the hazard unit
//   branch_taken      beq resolved taken in EX
//   branch_pc_plus4   PC+4 of that branch
//   branch_offset     raw 16-bit branch immediate (word offset)
//   jump              j decoded in ID
//   jump_index        instr[25:0] of the jump
//   if_id_instr       registered instruction
//   if_id_pc_plus4    registered PC+4 of that instruction
//   if_id_valid       0 marks a bubble
//   fetch_count       valid instructions written into IF/ID
//   stall_count       cycles spent in hold
module fetch_stage #(
  parameter int PC_W  = mips_pkg::PC_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_pc_plus4,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      if_id_instr,
  output logic [PC_W-1:0]  if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  import mips_pkg::*;

  npc_sel_e        sel;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] j_target;
  logic [PC_W-1:0] pc_next;

  assign imem_addr = pc;
  assign pc_plus4  = pc + PC_W'(4);

  // Word offset is sign-extended and scaled to bytes before truncation to PC_W.
  assign br_target = branch_pc_plus4
                   + PC_W'({{14{branch_offset[15]}}, branch_offset, 2'b00});
  assign j_target  = PC_W'({jump_index, 2'b00});

  // A taken branch squashes whatever is stalled or jumping behind it, so it
  // outranks both; a held j keeps asserting jump until the stall drops.
  always_comb begin
    sel = SEQ;
    if (branch_taken) begin
      sel = REDIRECT_BR;
    end else if (stall) begin
      sel = HOLD;
    end else if (jump) begin
      sel = REDIRECT_J;
    end
  end

  always_comb begin
    pc_next = pc;
    case (sel)
      REDIRECT_BR: pc_next = br_target;
      REDIRECT_J:  pc_next = j_target;
      HOLD:        pc_next = pc;
      default:     pc_next = pc_plus4;
    endcase
    // Keep the PC word-aligned even if an upstream target is not.
    pc_next[1:0] = 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else begin
      case (sel)
        SEQ: begin
          if_id_instr    <= imem_data;
          if_id_pc_plus4 <= pc_plus4;
          if_id_valid    <= 1'b1;
        end
        REDIRECT_BR, REDIRECT_J: begin
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fetch_perf_ctr #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (sel == SEQ),
    .stall_en   (sel == HOLD),
    .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [9:0]  branch_pc_plus4;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [9:0]  if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  logic [31:0] rom [256];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model state
  int unsigned m_pc, m_pc4, m_fc, m_sc;
  logic [31:0] m_instr;
  logic        m_valid;

  always #5 clk = ~clk;

  always_comb imem_data = rom[int'(imem_addr) / 4];

  fetch_stage #(
    .PC_W (10),
    .CNT_W(32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_pc_plus4(branch_pc_plus4),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_fc = 0; m_sc = 0; m_instr = 32'h0; m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    {22'h0, imem_addr},      m_pc);
    check({tag, ".instr"}, if_id_instr,             m_instr);
    check({tag, ".pc4"},   {22'h0, if_id_pc_plus4}, m_pc4);
    check({tag, ".valid"}, {31'h0, if_id_valid},    {31'h0, m_valid});
    check({tag, ".fcnt"},  fetch_count,             m_fc);
    check({tag, ".scnt"},  stall_count,             m_sc);
  endtask

  // Drive one cycle of control inputs, advance the model by the stated
  // priority rules, then compare after the edge.
  task automatic step(input string tag, input logic br, input logic st, input logic j,
                      input logic [9:0] bpc4, input logic [15:0] off, input logic [25:0] ji);
    int t;
    branch_taken = br; stall = st; jump = j;
    branch_pc_plus4 = bpc4; branch_offset = off; jump_index = ji;
    @(posedge clk);
    #1;
    if (br) begin
      t = int'(bpc4) + int'($signed(off)) * 4;
      m_pc = unsigned'(t) % 1024;
      m_pc = m_pc - (m_pc % 4);
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (st) begin
      m_sc++;
    end else if (j) begin
      m_pc = (int'(ji) * 4) % 1024;
      m_instr = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = rom[m_pc / 4];
      m_pc4   = (m_pc + 4) % 1024;
      m_pc    = m_pc4;
      m_valid = 1'b1;
      m_fc++;
    end
    branch_taken = 1'b0; stall = 1'b0; jump = 1'b0;
    check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 26'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    for (int i = 0; i < 10; i++) rom[i] = 32'h8C00_0000 | (i << 16) | (i * 4);
    rom[46] = 32'h8C0B_0000;
    rom[47] = 32'h0162_6020;
    rom[56] = 32'hAC0A_007C;
    rom[64] = 32'hAC09_0080;

    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_pc_plus4 = '0; branch_offset = '0; jump_index = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // sequential fetch of words 0..9
    for (int i = 0; i < 10; i++) seq("seq");
    check("seq_pc4_40", {22'h0, if_id_pc_plus4}, 32'd40);
    check("seq_fcnt_10", fetch_count, 32'd10);

    // load-use stall at word 47
    step("j46", 1'b0, 1'b0, 1'b1, 10'h0, 16'h0, 26'd46);
    seq("ld46");
    step("stall", 1'b0, 1'b1, 1'b0, 10'h0, 16'h0, 26'h0);
    check("stall_pc", {22'h0, imem_addr}, 32'h0BC);
    check("stall_holds_lw", if_id_instr, 32'h8C0B_0000);
    seq("after_stall");
    check("add47", if_id_instr, 32'h0162_6020);

    // taken branch
    step("br", 1'b1, 1'b0, 1'b0, 10'h0D4, 16'd3, 26'h0);
    check("br_pc", {22'h0, imem_addr}, 32'h0E0);
    check("br_bubble", {31'h0, if_id_valid}, 32'd0);
    seq("br_tgt");
    check("br_sw", if_id_instr, 32'hAC0A_007C);

    // jump
    step("jmp", 1'b0, 1'b0, 1'b1, 10'h0, 16'h0, 26'h40);
    check("j_pc", {22'h0, imem_addr}, 32'h100);
    seq("j_tgt");
    check("j_sw", if_id_instr, 32'hAC09_0080);

    // priority: branch over stall and jump, stall over jump
    step("prio_all", 1'b1, 1'b1, 1'b1, 10'h100, 16'hFFFE, 26'h10);
    check("prio_pc", {22'h0, imem_addr}, 32'h0F8);
    step("prio_sj", 1'b0, 1'b1, 1'b1, 10'h0, 16'h0, 26'h10);
    check("prio_hold_pc", {22'h0, imem_addr}, 32'h0F8);

    // wrap from the top of the address space
    step("j_top", 1'b0, 1'b0, 1'b1, 10'h0, 16'h0, 26'hFF);
    seq("wrap");
    check("wrap_pc", {22'h0, imem_addr}, 32'h000);
    check("wrap_pc4", {22'h0, if_id_pc_plus4}, 32'h000);

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic br, st, j;
      br = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 5) == 0);
      j  = ($urandom_range(0, 7) == 0);
      step("rand", br, st, j, 10'($urandom), 16'($urandom), 26'($urandom));
    end

    // asynchronous reset between edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    seq("restart");
    check("restart_instr", if_id_instr, rom[0]);
    check("restart_pc4", {22'h0, if_id_pc_plus4}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
